// File: rtl/wb_arb2.sv
// Two-master Wishbone arbiter for the shared 16-bit LSI-11 master bus.
// Master 0 is the CPU core, master 1 a DMA peripheral limited by a preemptable burst count.
module wb_arb2 #(
  parameter int ARB_RR    = 0,
  parameter int ARB_BURST = 8
) (
  input  logic        vm_clk_p,
  input  logic        vm_dclo,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [1:0]  m0_sel_i,
  input  logic [15:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  output logic        m0_gnt_o,
  output logic        m0_ack_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [1:0]  m1_sel_i,
  input  logic [15:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  output logic        m1_gnt_o,
  output logic        m1_ack_o,
  output logic [15:0] m_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [1:0]  s_sel_o,
  output logic [15:0] s_adr_o,
  output logic [15:0] s_dat_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  localparam logic       RR_EN      = (ARB_RR != 0);
  localparam logic       PREEMPT_EN = (ARB_BURST != 0);
  localparam logic [7:0] BURST_LAST = 8'(ARB_BURST - 1);

  state_t     r_state;
  state_t     w_state_nx;
  logic       r_last;
  logic       w_last_nx;
  logic [7:0] r_bcnt;
  logic [7:0] w_bcnt_nx;

  // State, last-served master and master-1 ack count
  always_ff @(posedge vm_clk_p or posedge vm_dclo) begin
    if (vm_dclo) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_bcnt  <= 8'd0;
    end else begin
      r_state <= w_state_nx;
      r_last  <= w_last_nx;
      r_bcnt  <= w_bcnt_nx;
    end
  end

  // Arbitration decision, burst counting and preemption
  always_comb begin
    w_state_nx = r_state;
    w_last_nx  = r_last;
    w_bcnt_nx  = r_bcnt;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || !RR_EN || r_last)) begin
          w_state_nx = ST_G0;
        end else if (m1_cyc_i) begin
          w_state_nx = ST_G1;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_G0: begin
        if (!m0_cyc_i) begin
          w_state_nx = m1_cyc_i ? ST_G1 : ST_IDLE;
        end else begin
          w_state_nx = ST_G0;
        end
      end
      ST_G1: begin
        if (s_ack_i && (r_bcnt != 8'hFF)) begin
          w_bcnt_nx = r_bcnt + 8'd1;
        end else begin
          w_bcnt_nx = r_bcnt;
        end
        if (!m1_cyc_i) begin
          w_state_nx = m0_cyc_i ? ST_G0 : ST_IDLE;
        end else if (PREEMPT_EN && s_ack_i && (r_bcnt == BURST_LAST) && m0_cyc_i) begin
          w_state_nx = ST_G0;
        end else begin
          w_state_nx = ST_G1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
    // A fresh grant records the winner; a fresh master-1 grant restarts its burst
    if ((w_state_nx == ST_G0) && (r_state != ST_G0)) begin
      w_last_nx = 1'b0;
    end else if ((w_state_nx == ST_G1) && (r_state != ST_G1)) begin
      w_last_nx = 1'b1;
      w_bcnt_nx = 8'd0;
    end else begin
      w_last_nx = w_last_nx;
    end
  end

  assign m0_gnt_o = (r_state == ST_G0);
  assign m1_gnt_o = (r_state == ST_G1);
  assign m_dat_o  = s_dat_i;

  // Slave bus mux and ack routing from the current grant
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = 2'b11;
    s_adr_o  = 16'h0000;
    s_dat_o  = 16'h0000;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    case (r_state)
      ST_G0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & m0_gnt_o;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
      end
      ST_G1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & m1_gnt_o;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
      end
      default: begin
        s_cyc_o = 1'b0;
      end
    endcase
  end

endmodule
